// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX pipeline control slice.
package dlx_pkg;

    localparam int unsigned REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/dlx_hazard_detect.sv
// Combinational load-use comparator; also flags when a taken branch overrides the stall.
import dlx_pkg::*;

module dlx_hazard_detect (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    output logic              hazard,
    output logic              branch_override
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match       = (ex_rd == id_rs1);
        rs2_match       = id_uses_rs2 && (ex_rd == id_rs2);
        hazard          = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_match || rs2_match);
        // the instruction in ID is flushed by the branch, so it never needs the stall
        branch_override = hazard && ex_branch_taken;
    end

endmodule

// File: rtl/dlx_pipe_ctrl.sv
// Pipeline sequencing for the 5-stage DLX: memory freeze, branch flush, load-use stall,
// saturating stall counter and sticky memory-timeout error.
import dlx_pkg::*;

module dlx_pipe_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_access,
    input  logic              dmem_ack,
    output logic              dmem_req,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_mem_en,
    output logic              mem_wb_bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              mem_err
);

    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

    ctrl_state_e state, state_nxt;
    logic [15:0] wait_cnt, wait_nxt;
    logic        hazard;
    logic        branch_override;
    logic        freeze;
    logic        hazard_ctrl;

    dlx_hazard_detect u_hazard (
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .hazard          (hazard),
        .branch_override (branch_override)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (!pc_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (state_nxt == ERR)
                mem_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        freeze        = 1'b0;
        hazard_ctrl   = 1'b0;
        dmem_req      = 1'b0;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;

        unique case (state)
            RUN: begin
                dmem_req = mem_access;
                if (mem_access && !dmem_ack) begin
                    freeze    = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = 16'd1;
                end else begin
                    hazard_ctrl = 1'b1;
                end
            end
            MEM_WAIT: begin
                dmem_req = mem_access;
                if (dmem_ack) begin
                    // release cycle: branch and load-use are honoured as the stages advance
                    hazard_ctrl = 1'b1;
                    state_nxt   = RUN;
                    wait_nxt    = '0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == TIMEOUT_V) begin
                        state_nxt = ERR;
                        wait_nxt  = '0;
                    end else begin
                        wait_nxt = wait_cnt + 16'd1;
                    end
                end
            end
            default: freeze = 1'b1;
        endcase

        if (freeze) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (hazard_ctrl && ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (hazard_ctrl && hazard && !branch_override) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end

        if (reset) begin
            dmem_req      = 1'b0;
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_bubble  = 1'b0;
            mem_wb_bubble = 1'b0;
        end
    end

endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// Scoreboard bench for dlx_pipe_ctrl: directed scenarios then randomized traffic vs a reference model.
module tb_dlx_pipe_ctrl;

    localparam int TO_TB = 4;
    localparam int CW_TB = 4;
    localparam int CNT_MAX = (1 << CW_TB) - 1;

    typedef struct packed {
        logic [7:0]       ctrl;
        logic [CW_TB-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs2, ex_mem_read, ex_branch_taken, mem_access, dmem_ack;
    logic             dmem_req, pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en;
    logic             mem_wb_bubble, mem_err;
    logic [CW_TB-1:0] stall_cnt;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // reference model state
    bit m_err = 0;
    bit m_wait = 0;
    int m_wcnt = 0;
    int m_stalls = 0;

    dlx_pipe_ctrl #(.TIMEOUT(TO_TB), .CNT_W(CW_TB)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_access      (mem_access),
        .dmem_ack        (dmem_ack),
        .dmem_req        (dmem_req),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_bubble   (mem_wb_bubble),
        .stall_cnt       (stall_cnt),
        .mem_err         (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every cycle the DUT presents a full set of outputs
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] got;
            e   = q.pop_front();
            got = {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_bubble, mem_err};
            checks++;
            if (got !== e.ctrl) begin
                errors++;
                $display("FAIL ctrl cyc=%0d got(req,pc,ifid,flush,idb,exm,wbb,err)=%b exp=%b", cyc, got, e.ctrl);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++;
                $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, e.cnt);
            end
        end
    end

    // Compute this cycle's expected outputs from the current inputs, queue them, advance the model.
    task automatic step();
        bit req, pc, ifid, flush, idb, exm, wbb, frz, hz;
        exp_t e;
        req = 0; pc = 0; ifid = 0; flush = 0; idb = 0; exm = 0; wbb = 0;
        if (reset) begin
            m_err = 0; m_wait = 0; m_wcnt = 0; m_stalls = 0;
            e.ctrl = 8'b0;
            e.cnt  = '0;
        end else begin
            hz = ex_mem_read && (ex_rd != 0) &&
                 ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
            pc = 1; ifid = 1; exm = 1;
            if (m_err) frz = 1;
            else begin
                req = mem_access;
                frz = m_wait ? !dmem_ack : (mem_access && !dmem_ack);
            end
            if (frz) begin
                pc = 0; ifid = 0; exm = 0; wbb = 1;
            end else if (ex_branch_taken) begin
                flush = 1; idb = 1;
            end else if (hz) begin
                pc = 0; ifid = 0; idb = 1;
            end
            e.ctrl = {req, pc, ifid, flush, idb, exm, wbb, m_err};
            e.cnt  = CW_TB'(m_stalls);
            if (!pc && m_stalls < CNT_MAX) m_stalls++;
            if (!m_err) begin
                if (m_wait) begin
                    if (dmem_ack) m_wait = 0;
                    else if (m_wcnt == TO_TB) begin m_err = 1; m_wait = 0; end
                    else m_wcnt++;
                end else if (mem_access && !dmem_ack) begin
                    m_wait = 1; m_wcnt = 1;
                end
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        reset = 0; id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs2 = 0; ex_rd = 5'd3;
        ex_mem_read = 0; ex_branch_taken = 0; mem_access = 0; dmem_ack = 0;
    endtask

    initial begin
        int err_run;
        idle();
        reset = 1;
        @(posedge clk);
        #1;
        step(); step();
        idle(); step();

        // load-use on rs1
        ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; step();
        // r0 never hazards; unused rs2 never hazards
        idle(); ex_mem_read = 1; ex_rd = 5'd0; id_rs1 = 5'd0; step();
        idle(); ex_mem_read = 1; ex_rd = 5'd7; id_rs2 = 5'd7; step();
        // used rs2 does
        id_uses_rs2 = 1; step();
        // taken branch overrides load-use
        idle(); ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; ex_branch_taken = 1; step();

        // memory wait: 3 frozen cycles then ack
        idle(); mem_access = 1;
        for (int i = 0; i < 3; i++) step();
        dmem_ack = 1; step();
        idle(); step();

        // timeout into ERR, then reset pulse
        mem_access = 1;
        for (int i = 0; i < 8; i++) step();
        reset = 1; step();
        idle(); step();

        // reset asserted on the 2nd wait cycle aborts the access
        mem_access = 1; step(); step();
        reset = 1; step();
        reset = 0; step();
        dmem_ack = 1; step();
        idle(); step();

        // randomized traffic
        err_run = 0;
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(0, 299) == 0) || (err_run >= 3);
            id_rs1          = 5'($urandom_range(0, 7));
            id_rs2          = 5'($urandom_range(0, 7));
            ex_rd           = 5'($urandom_range(0, 7));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 99) < 50);
            ex_branch_taken = ($urandom_range(0, 99) < 20);
            mem_access      = ($urandom_range(0, 99) < 35);
            dmem_ack        = ($urandom_range(0, 99) < 35);
            err_run         = m_err ? err_run + 1 : 0;
            step();
        end

        idle(); step();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlx_pipe_ctrl.md
Name: dlx_pipe_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage DLX core. It generates stage enables, bubble inserts and flushes for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It covers three hazard sources: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses in MEM through a req/ack handshake. It also keeps a saturating stall counter and a sticky memory-timeout error.

Parameters:
TIMEOUT, 64, maximum MEM_WAIT cycles before a memory error is declared (range 2..65535).
CNT_W, 16, width of the stall performance counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
id_rs1  in  5  source register 1 of the instruction in ID.
id_rs2  in  5  source register 2 of the instruction in ID.
id_uses_rs2  in  1  the ID instruction reads rs2.
ex_rd  in  5  destination register of the instruction in EX.
ex_mem_read  in  1  the EX instruction is a load.
ex_branch_taken  in  1  a branch or jump resolved taken in EX.
mem_access  in  1  the MEM instruction is a load or store.
dmem_ack  in  1  data memory completes the access this cycle.
dmem_req  out  1  data-memory request, held until ack.
pc_en  out  1  PC update enable.
if_id_en  out  1  IF/ID register load enable.
if_id_flush  out  1  IF/ID register loads a NOP.
id_ex_bubble  out  1  ID/EX register loads zeroed control signals.
ex_mem_en  out  1  EX/MEM register load enable.
mem_wb_bubble  out  1  MEM/WB register loads reg_write=0 and mem_to_reg=0.
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0.
mem_err  out  1  sticky timeout error.

Behaviour:
- State register values: RUN, MEM_WAIT, ERR. Reset forces RUN, wait counter 0, stall_cnt 0 and mem_err 0.
- Outputs are combinational from the state and current inputs. Only the state, wait counter, stall_cnt and mem_err are registered.
- Defaults: pc_en=1, if_id_en=1, ex_mem_en=1, all flush/bubble outputs 0, dmem_req=0.
- While reset is high, all enables are 0 and all bubbles and flushes are 0.
- Memory handshake:
  - dmem_req = mem_access while in RUN or MEM_WAIT.
  - RUN with mem_access=1 and dmem_ack=1: single-cycle access, no stall.
  - RUN with mem_access=1 and dmem_ack=0: the next state is MEM_WAIT and the wait counter loads 1. In the same cycle pc_en, if_id_en and ex_mem_en are 0 and mem_wb_bubble is 1.
  - MEM_WAIT with dmem_ack=0: keep all stages frozen and set mem_wb_bubble=1. The wait counter increments.
  - MEM_WAIT with dmem_ack=1: all stages advance in this cycle, mem_wb_bubble=0, and the next state is RUN.
  - MEM_WAIT with the counter equal to TIMEOUT and no ack: the next state is ERR and mem_err is set.
  - Ack on the TIMEOUT cycle wins; no error is raised.
- ERR: all stages frozen, mem_wb_bubble=1, dmem_req=0. mem_err stays 1. Only reset exits this state.
- Load-use hazard, evaluated in RUN only:
  - hazard = ex_mem_read AND ex_rd!=0 AND (ex_rd==id_rs1 OR (id_uses_rs2 AND ex_rd==id_rs2)).
  - Response: pc_en=0, if_id_en=0, id_ex_bubble=1. EX/MEM advances normally.
- Taken branch in RUN: if_id_flush=1 and id_ex_bubble=1. pc_en stays 1 so the target is fetched.
- Priority: memory freeze (MEM_WAIT, ERR, or RUN-miss) > branch > load-use. A taken branch suppresses a simultaneous load-use stall; the flushed instruction needs no stall.
- During a memory freeze, ex_branch_taken and the hazard inputs are ignored. They are re-evaluated on the release cycle.
- stall_cnt increments on every cycle with pc_en=0 outside reset, including the ERR state. It saturates at all-ones.
- Register r0 never creates a hazard.
- An asynchronous reset in MEM_WAIT aborts the access immediately: dmem_req drops during reset.

Decomposition:
- Shared package dlx_pkg holds:
  - the state encoding constants (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2);
  - the REG_ZERO constant 5'd0;
  - the register address width 5.
- Natural sub-module: dlx_hazard_detect. It is the pure combinational load-use comparator, with outputs hazard and a branch-override flag.
- The FSM, counters and output muxing stay in dlx_pipe_ctrl.

Test Plan:
- Load-use hazard: ex_mem_read=1, ex_rd=5, id_rs1=5, no memory access -> one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1; stall_cnt goes 0->1.
- No hazard on r0 or unused rs2: ex_rd=0 with id_rs1=0 -> no stall. Then ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall.
- Branch over load-use: ex_branch_taken=1 together with the load-use hazard -> if_id_flush=1, id_ex_bubble=1, pc_en=1; stall_cnt unchanged.
- Memory wait: mem_access=1, dmem_ack low for 3 cycles then high -> 3 cycles frozen with mem_wb_bubble=1, all stages advance on the ack cycle; stall_cnt +3; state returns to RUN.
- Timeout: TIMEOUT=4, dmem_ack never asserted -> ERR entered after the 4th wait cycle, mem_err=1, dmem_req=0. A reset pulse clears to RUN with mem_err=0.
- Reset during MEM_WAIT at cycle 2 -> all outputs at reset values immediately; normal flow resumes after reset release.
